// File: rtl/kch_update_ctrl_if.sv
// Heartbeat message handshake from the packet parser plus the knownCH update bus.
// master: parser/table side, slave: kch_update_ctrl.
interface kch_update_ctrl_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic                  msg_valid;
  logic                  msg_ready;
  logic [WORD_WIDTH-1:0] msg_ID;
  logic [WORD_WIDTH-1:0] msg_Hops;
  logic [WORD_WIDTH-1:0] msg_QValue;
  logic                  en_KCH;
  logic                  HB_reset;
  logic [WORD_WIDTH-1:0] fCH_ID;
  logic [WORD_WIDTH-1:0] fCH_Hops;
  logic [WORD_WIDTH-1:0] fCH_QValue;

  modport master (
    output msg_valid, msg_ID, msg_Hops, msg_QValue,
    input  msg_ready, en_KCH, HB_reset, fCH_ID, fCH_Hops, fCH_QValue
  );

  modport slave (
    input  msg_valid, msg_ID, msg_Hops, msg_QValue,
    output msg_ready, en_KCH, HB_reset, fCH_ID, fCH_Hops, fCH_QValue
  );
endinterface

// File: rtl/kch_update_ctrl.sv
// knownCH update sequencer: buffers heartbeat messages, replays each one as a single
// en_KCH strobe followed by a settle window, and issues HB_reset on timeout/round start.
module kch_update_ctrl #(
  parameter int unsigned          WORD_WIDTH    = 16,
  parameter int unsigned          FIFO_DEPTH    = 4,
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter int unsigned          HB_TIMEOUT    = 1000,
  parameter logic [WORD_WIDTH-1:0] INVALID_HOPS = '1
) (
  input  logic                   clk,
  input  logic                   nrst,
  kch_update_ctrl_if.slave       bus,
  input  logic                   round_start,
  output logic                   kch_busy,
  output logic [7:0]             drop_cnt
);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned TimerW  = $clog2(HB_TIMEOUT);
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TimerW-1:0]  TimerMax   = TimerW'(HB_TIMEOUT - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [PtrW:0]      FullCount  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StPulse, StSettle, StResetHb} stateT;

  stateT                     stateQ, stateD;
  logic                      runQ;
  logic [SettleW-1:0]        settleQ, settleD;
  logic [PtrW-1:0]           wrPtrQ, rdPtrQ;
  logic [PtrW:0]             countQ;
  logic [3*WORD_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [TimerW-1:0]         timerQ, timerD;
  logic                      hbReqQ, hbReqD;
  logic [7:0]                dropQ, dropD;
  logic [WORD_WIDTH-1:0]     fchIdQ, fchHopsQ, fchQValQ;
  logic                      msgReady, accept, push, dropMsg, pop, flush;

  // runQ keeps msg_ready low while nrst is asserted, using registered state only
  assign msgReady = runQ && (countQ != FullCount) && (stateQ != StResetHb);
  assign accept   = bus.msg_valid && msgReady;
  assign dropMsg  = accept && (bus.msg_Hops == INVALID_HOPS);
  assign push     = accept && (bus.msg_Hops != INVALID_HOPS);
  assign pop      = (stateQ == StLoad);
  assign flush    = (stateQ == StResetHb);

  // FSM state, settle counter and handshake enable
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateQ  <= StIdle;
      settleQ <= '0;
      runQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      settleQ <= settleD;
      runQ    <= 1'b1;
    end
  end

  // Next state: pending hb_req beats queued data; an update in flight always completes
  always_comb begin
    stateD  = stateQ;
    settleD = settleQ;
    case (stateQ)
      StIdle: begin
        if (hbReqQ) begin
          stateD = StResetHb;
        end else if (countQ != '0) begin
          stateD = StLoad;
        end
      end
      StLoad:  stateD = StPulse;
      StPulse: begin
        stateD  = StSettle;
        settleD = '0;
      end
      StSettle: begin
        if (settleQ == SettleLast) begin
          stateD = StIdle;
        end else begin
          settleD = settleQ + SettleW'(1);
        end
      end
      StResetHb: stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  // FIFO pointers and occupancy; a flush empties the buffer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else if (flush) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
      if (pop)  rdPtrQ <= rdPtrQ + PtrW'(1);
      countQ <= countQ + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end
  end

  // FIFO storage, no reset needed since occupancy guards reads
  always_ff @(posedge clk) begin
    if (push) mem[wrPtrQ] <= {bus.msg_ID, bus.msg_Hops, bus.msg_QValue};
  end

  // Field registers change only in LOAD and survive HB_reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fchIdQ   <= '0;
      fchHopsQ <= INVALID_HOPS;
      fchQValQ <= '0;
    end else if (pop) begin
      {fchIdQ, fchHopsQ, fchQValQ} <= mem[rdPtrQ];
    end
  end

  // Heartbeat timer, sticky reset request and saturating drop counter
  always_comb begin
    timerD = timerQ;
    hbReqD = hbReqQ;
    dropD  = dropQ;
    if (flush || push) begin
      timerD = '0;
    end else if (timerQ != TimerMax) begin
      timerD = timerQ + TimerW'(1);
    end
    // The table is being cleared this cycle, so a coincident request is already served
    if (flush) begin
      hbReqD = 1'b0;
    end else if (round_start || (timerQ == TimerMax)) begin
      hbReqD = 1'b1;
    end
    if (dropMsg && (dropQ != 8'hFF)) begin
      dropD = dropQ + 8'd1;
    end
  end

  // Timer, request and drop counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timerQ <= '0;
      hbReqQ <= 1'b0;
      dropQ  <= '0;
    end else begin
      timerQ <= timerD;
      hbReqQ <= hbReqD;
      dropQ  <= dropD;
    end
  end

  assign bus.msg_ready  = msgReady;
  assign bus.en_KCH     = (stateQ == StPulse);
  assign bus.HB_reset   = (stateQ == StResetHb);
  assign bus.fCH_ID     = fchIdQ;
  assign bus.fCH_Hops   = fchHopsQ;
  assign bus.fCH_QValue = fchQValQ;
  assign kch_busy       = (stateQ != StIdle) || (countQ != '0);
  assign drop_cnt       = dropQ;
endmodule
